// File: rtl/hdlc_rx_reader.sv
// hdlc_rx_reader
// Receive drain engine that sits behind the HDLC controller register port.
// When the controller reports a buffered frame it reads Rx_SC and Rx_Len,
// then either streams the payload out as a valid/ready byte stream or
// writes the Drop command back to Rx_SC.
//
// Ports
//   Clk, Rst            clock, synchronous active-high reset
//   Rx_Ready            controller holds a complete frame
//   Address/WriteEnable/ReadEnable/WrData/RdData
//                       controller register bus (RdData valid the cycle
//                       after ReadEnable)
//   M_Data/M_Valid/M_Ready/M_First/M_Last
//                       payload byte stream
//   FrameDone           one-cycle pulse after the last byte is accepted
//   FrameDropped        one-cycle pulse while the drop write is on the bus
//   FrameCount          delivered frames (wraps)
//   DropCount           dropped frames (saturates)
module hdlc_rx_reader #(
  parameter int MAX_FRAME = 126,
  parameter int CNT_W     = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Rx_Ready,
  output logic [2:0]       Address,
  output logic             WriteEnable,
  output logic             ReadEnable,
  output logic [7:0]       WrData,
  input  logic [7:0]       RdData,
  output logic [7:0]       M_Data,
  output logic             M_Valid,
  input  logic             M_Ready,
  output logic             M_First,
  output logic             M_Last,
  output logic             FrameDone,
  output logic             FrameDropped,
  output logic [CNT_W-1:0] FrameCount,
  output logic [CNT_W-1:0] DropCount
);

  localparam logic [2:0] ADDR_SC  = 3'd2;
  localparam logic [2:0] ADDR_BUF = 3'd3;
  localparam logic [2:0] ADDR_LEN = 3'd4;
  localparam logic [7:0] CMD_DROP = 8'h02;
  localparam logic [8:0] MAX_LEN  = 9'(MAX_FRAME);

  typedef enum logic [3:0] {
    S_IDLE,
    S_RD_SC,
    S_CAP_SC,
    S_RD_LEN,
    S_CAP_LEN,
    S_RD_BUF,
    S_CAP_BUF,
    S_PUSH,
    S_DROP,
    S_GAP
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       len_q, len_d;
  logic [7:0]       idx_q, idx_d;
  logic [7:0]       data_q, data_d;
  logic [2:0]       addr_q, addr_d;
  logic             we_q, we_d;
  logic             re_q, re_d;
  logic [7:0]       wr_q, wr_d;
  logic             done_q, done_d;
  logic             drop_q, drop_d;
  logic [CNT_W-1:0] fcnt_q, fcnt_d;
  logic [CNT_W-1:0] dcnt_q, dcnt_d;
  logic             is_last;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // len is at least 1 whenever PUSH is reachable, so len-1 never wraps there.
  assign is_last = (idx_q == len_q - 8'd1);

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    data_d  = data_q;
    done_d  = 1'b0;
    fcnt_d  = fcnt_q;

    case (state_q)
      S_IDLE:    if (Rx_Ready) state_d = S_RD_SC;
      S_RD_SC:   state_d = S_CAP_SC;
      S_CAP_SC:  state_d = (|RdData[4:2]) ? S_DROP : S_RD_LEN;
      S_RD_LEN:  state_d = S_CAP_LEN;
      S_CAP_LEN: begin
        len_d = RdData;
        idx_d = 8'd0;
        if (RdData == 8'd0 || {1'b0, RdData} > MAX_LEN) state_d = S_DROP;
        else                                             state_d = S_RD_BUF;
      end
      S_RD_BUF:  state_d = S_CAP_BUF;
      S_CAP_BUF: begin
        data_d  = RdData;
        state_d = S_PUSH;
      end
      S_PUSH: begin
        if (M_Ready) begin
          idx_d = idx_q + 8'd1;
          if (is_last) begin
            done_d  = 1'b1;
            fcnt_d  = fcnt_q + CNT_W'(1);
            state_d = S_GAP;
          end else begin
            state_d = S_RD_BUF;
          end
        end
      end
      S_DROP:    state_d = S_GAP;
      // Holding here until Rx_Ready drops keeps the same frame from being
      // read a second time while the controller clears its flag.
      S_GAP:     if (!Rx_Ready) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase

    // Bus strobes are registered, so they are decoded from the state being
    // entered; they then appear in the same cycle as that state.
    re_d   = (state_d == S_RD_SC) || (state_d == S_RD_LEN) || (state_d == S_RD_BUF);
    we_d   = (state_d == S_DROP);
    drop_d = (state_d == S_DROP);
    wr_d   = (state_d == S_DROP) ? CMD_DROP : 8'h00;
    case (state_d)
      S_RD_SC:  addr_d = ADDR_SC;
      S_RD_LEN: addr_d = ADDR_LEN;
      S_RD_BUF: addr_d = ADDR_BUF;
      S_DROP:   addr_d = ADDR_SC;
      default:  addr_d = 3'd0;
    endcase
    dcnt_d = drop_d ? sat_inc(dcnt_q) : dcnt_q;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= S_IDLE;
      len_q   <= 8'd0;
      idx_q   <= 8'd0;
      data_q  <= 8'd0;
      addr_q  <= 3'd0;
      we_q    <= 1'b0;
      re_q    <= 1'b0;
      wr_q    <= 8'd0;
      done_q  <= 1'b0;
      drop_q  <= 1'b0;
      fcnt_q  <= '0;
      dcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      re_q    <= re_d;
      wr_q    <= wr_d;
      done_q  <= done_d;
      drop_q  <= drop_d;
      fcnt_q  <= fcnt_d;
      dcnt_q  <= dcnt_d;
    end
  end

  assign Address      = addr_q;
  assign WriteEnable  = we_q;
  assign ReadEnable   = re_q;
  assign WrData       = wr_q;
  assign M_Data       = data_q;
  assign M_Valid      = (state_q == S_PUSH);
  assign M_First      = M_Valid && (idx_q == 8'd0);
  assign M_Last       = M_Valid && is_last;
  assign FrameDone    = done_q;
  assign FrameDropped = drop_q;
  assign FrameCount   = fcnt_q;
  assign DropCount    = dcnt_q;

endmodule

// File: tb/tb_hdlc_rx_reader.sv
// Testbench for hdlc_rx_reader: a register-level model of the HDLC
// controller answers reads, a frame-level model predicts the byte stream
// and counters, and a negedge monitor compares the DUT every cycle.
module tb_hdlc_rx_reader;

  localparam int MAX_FRAME = 126;
  localparam int CNT_W     = 16;

  logic             Clk = 1'b0;
  logic             Rst;
  logic             Rx_Ready;
  logic [2:0]       Address;
  logic             WriteEnable;
  logic             ReadEnable;
  logic [7:0]       WrData;
  logic [7:0]       RdData = 8'h00;
  logic [7:0]       M_Data;
  logic             M_Valid;
  logic             M_Ready;
  logic             M_First;
  logic             M_Last;
  logic             FrameDone;
  logic             FrameDropped;
  logic [CNT_W-1:0] FrameCount;
  logic [CNT_W-1:0] DropCount;

  hdlc_rx_reader #(.MAX_FRAME(MAX_FRAME), .CNT_W(CNT_W)) dut (
    .Clk(Clk), .Rst(Rst), .Rx_Ready(Rx_Ready),
    .Address(Address), .WriteEnable(WriteEnable), .ReadEnable(ReadEnable),
    .WrData(WrData), .RdData(RdData),
    .M_Data(M_Data), .M_Valid(M_Valid), .M_Ready(M_Ready),
    .M_First(M_First), .M_Last(M_Last),
    .FrameDone(FrameDone), .FrameDropped(FrameDropped),
    .FrameCount(FrameCount), .DropCount(DropCount)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  // ---------------- controller register model ----------------
  logic [7:0] cur_sc, cur_len;
  logic [7:0] fifo_mem [0:255];
  int         rd_ptr = 0;
  bit         rd_pend = 1'b0;
  logic [7:0] rd_pend_val = 8'h00;
  int n_rd_sc = 0, n_rd_len = 0, n_rd_buf = 0, n_rd_bad = 0;
  int n_wr_drop = 0, n_wr_other = 0;

  // Read data is only presented during the cycle after ReadEnable; any
  // other cycle carries a junk value so early/late capture is visible.
  always @(negedge Clk) begin
    if (rd_pend) RdData = rd_pend_val;
    else         RdData = 8'hEE;
    rd_pend = 1'b0;
    if (Rst) begin
      rd_ptr = 0;
    end else begin
      if (ReadEnable) begin
        rd_pend = 1'b1;
        case (Address)
          3'd2: begin rd_pend_val = cur_sc;  rd_ptr = 0; n_rd_sc++; end
          3'd4: begin rd_pend_val = cur_len; n_rd_len++; end
          3'd3: begin rd_pend_val = fifo_mem[rd_ptr[7:0]]; rd_ptr++; n_rd_buf++; end
          default: begin rd_pend_val = 8'h00; n_rd_bad++; end
        endcase
      end
      if (WriteEnable) begin
        if (Address == 3'd2 && WrData == 8'h02) n_wr_drop++;
        else                                    n_wr_other++;
      end
    end
  end

  // ---------------- expected stream and monitor ----------------
  typedef struct {
    logic [7:0] data;
    logic       first;
    logic       last;
  } exp_t;
  exp_t exp_q[$];

  int         model_frames = 0;
  int         t_rdsc = -1;
  int         t_last_acc = -100;
  int         last_acc_cyc = -1;
  int         acc_cnt = 0;
  bit         hold_pend = 1'b0;
  bit         stalled = 1'b0;
  logic [9:0] hold_vals = '0;

  always @(negedge Clk) begin
    bit   was_hold;
    exp_t e;
    if (Rst) begin
      exp_q.delete();
      model_frames = 0;
      hold_pend    = 1'b0;
      stalled      = 1'b0;
      acc_cnt      = 0;
      last_acc_cyc = -1;
      t_rdsc       = -1;
    end else begin
      was_hold = hold_pend;
      if (ReadEnable || WriteEnable) chk("strobe_exclusive", ReadEnable && WriteEnable, 0);
      else                           chk("idle_bus_zero", {Address, WrData}, 0);
      if (ReadEnable && Address == 3'd2) t_rdsc = cyc;
      if (!M_Valid) chk("flags_without_valid", {M_First, M_Last}, 0);
      else          chk("no_read_while_valid", ReadEnable, 0);
      if (was_hold) chk("hold_stable", {M_Valid, M_Data, M_First, M_Last}, {1'b1, hold_vals});
      hold_pend = 1'b0;
      if (M_Valid) begin
        if (M_First && !was_hold) chk("first_latency", cyc - t_rdsc, 6);
        if (!M_Ready) begin
          hold_pend = 1'b1;
          hold_vals = {M_Data, M_First, M_Last};
          stalled   = 1'b1;
        end else if (exp_q.size() == 0) begin
          chk("unexpected_byte", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          chk("byte", {M_Data, M_First, M_Last}, {e.data, e.first, e.last});
          if (!e.first && !stalled) chk("byte_rate", cyc - last_acc_cyc, 3);
          last_acc_cyc = cyc;
          stalled      = 1'b0;
          acc_cnt++;
          if (e.last) begin
            model_frames++;
            t_last_acc = cyc;
            acc_cnt    = 0;
          end
        end
      end
      if (FrameDone) begin
        chk("done_timing", cyc - t_last_acc, 1);
        chk("done_frame_count", FrameCount, model_frames);
      end
      if (FrameDropped) chk("drop_with_write", WriteEnable, 1);
    end
  end

  // ---------------- frame-level stimulus ----------------
  int exp_frames = 0;
  int exp_drops  = 0;

  task automatic run_frame(input logic [7:0] sc, input logic [7:0] len,
                           input int stall_idx, input int stall_cyc, input int gap_hold);
    bit sc_err, drop, done;
    int s_sc, s_len, s_buf, s_wd, s_wo, s_bad, s_hold, left, t_rise;
    sc_err = (sc & 8'h1C) != 8'h00;
    drop   = sc_err || len == 8'd0 || int'(len) > MAX_FRAME;
    cur_sc  = sc;
    cur_len = len;
    s_sc = n_rd_sc; s_len = n_rd_len; s_buf = n_rd_buf;
    s_wd = n_wr_drop; s_wo = n_wr_other; s_bad = n_rd_bad;
    if (drop) begin
      if (exp_drops < 65535) exp_drops++;
    end else begin
      for (int i = 0; i < int'(len); i++)
        exp_q.push_back('{data: fifo_mem[i], first: (i == 0), last: (i == int'(len) - 1)});
      exp_frames++;
    end
    t_rise   = cyc;
    Rx_Ready = 1'b1;
    M_Ready  = 1'b1;
    left     = stall_cyc;
    done     = 1'b0;
    for (int c = 0; c < 3000 && !done; c++) begin
      @(posedge Clk); #1;
      if (M_Valid && acc_cnt == stall_idx && left > 0) begin
        M_Ready = 1'b0;
        left--;
      end else begin
        M_Ready = 1'b1;
      end
      if (FrameDone || FrameDropped) done = 1'b1;
    end
    chk("frame_end_seen", done, 1);
    if (gap_hold > 0) begin
      s_hold = n_rd_sc;
      repeat (gap_hold) begin @(posedge Clk); #1; end
      chk("gap_hold_no_read", n_rd_sc - s_hold, 0);
    end
    Rx_Ready = 1'b0;
    repeat (3) begin @(posedge Clk); #1; end
    chk("ready_to_rdsc", t_rdsc - t_rise, 1);
    chk("reads_sc", n_rd_sc - s_sc, 1);
    chk("reads_len", n_rd_len - s_len, sc_err ? 0 : 1);
    chk("reads_buf", n_rd_buf - s_buf, drop ? 0 : int'(len));
    chk("reads_bad_addr", n_rd_bad - s_bad, 0);
    chk("drop_writes", n_wr_drop - s_wd, drop ? 1 : 0);
    chk("other_writes", n_wr_other - s_wo, 0);
    chk("stream_leftover", exp_q.size(), 0);
    chk("frame_count", FrameCount, exp_frames);
    chk("drop_count", DropCount, exp_drops);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    cur_sc = 8'h00; cur_len = 8'h00;
    for (int i = 0; i < 256; i++) fifo_mem[i] = 8'h00;
    Rst = 1'b1; Rx_Ready = 1'b0; M_Ready = 1'b1;
    repeat (3) begin @(posedge Clk); #1; end
    chk("reset_outputs", {Address, WriteEnable, ReadEnable, WrData, M_Data, M_Valid, M_First,
                          M_Last, FrameDone, FrameDropped, FrameCount, DropCount}, 0);
    Rst = 1'b0;
    @(posedge Clk); #1;

    // good frame
    fifo_mem[0] = 8'hA5; fifo_mem[1] = 8'h5A; fifo_mem[2] = 8'hFF;
    run_frame(8'h01, 8'd3, -1, 0, 0);
    chk("good_frame_count_lit", FrameCount, 1);
    chk("good_drop_count_lit", DropCount, 0);

    // backpressure on second byte
    run_frame(8'h01, 8'd3, 1, 4, 0);
    chk("bp_frame_count_lit", FrameCount, 2);

    // status error drops: Overflow, FrameError, AbortSignal
    run_frame(8'h11, 8'd3, -1, 0, 0);
    chk("err_drop_count_lit", DropCount, 1);
    run_frame(8'h05, 8'd3, -1, 0, 0);
    run_frame(8'h09, 8'd3, -1, 0, 0);
    chk("err3_drop_count_lit", DropCount, 3);

    // length bounds
    run_frame(8'h01, 8'd0, -1, 0, 0);
    run_frame(8'h01, 8'd127, -1, 0, 0);
    chk("len_drop_count_lit", DropCount, 5);
    for (int i = 0; i < 126; i++) fifo_mem[i] = 8'(i * 7 + 3);
    run_frame(8'h01, 8'd126, -1, 0, 0);
    chk("max_frame_count_lit", FrameCount, 3);

    // single-byte frame with Rx_Ready held through GAP
    fifo_mem[0] = 8'hC3;
    run_frame(8'h01, 8'd1, -1, 0, 20);
    chk("gap_frame_count_lit", FrameCount, 4);

    // reset during PUSH of byte 2 of 5
    for (int i = 0; i < 5; i++) fifo_mem[i] = 8'(8'h11 * (i + 1));
    cur_sc = 8'h01; cur_len = 8'd5;
    for (int i = 0; i < 5; i++)
      exp_q.push_back('{data: fifo_mem[i], first: (i == 0), last: (i == 4)});
    Rx_Ready = 1'b1; M_Ready = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      @(posedge Clk); #1;
      if (M_Valid && acc_cnt == 1) found = 1'b1;
    end
    chk("reach_second_byte", found, 1);
    Rst = 1'b1; M_Ready = 1'b0; Rx_Ready = 1'b0;
    @(posedge Clk); #1;
    chk("midframe_reset_outputs", {Address, WriteEnable, ReadEnable, WrData, M_Data, M_Valid,
                                   M_First, M_Last, FrameDone, FrameDropped, FrameCount,
                                   DropCount}, 0);
    exp_frames = 0; exp_drops = 0;
    Rst = 1'b0; M_Ready = 1'b1;
    @(posedge Clk); #1;
    fifo_mem[0] = 8'h21; fifo_mem[1] = 8'h42; fifo_mem[2] = 8'h84;
    run_frame(8'h01, 8'd3, -1, 0, 0);
    chk("post_reset_frame_count_lit", FrameCount, 1);
    chk("post_reset_drop_count_lit", DropCount, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hdlc_rx_reader.md
# hdlc_rx_reader

Host-side receive drain engine that sits directly downstream of the `Hdlc` controller's register interface. It waits for `Rx_Ready` and reads the Rx status and length registers. It then either streams the frame's payload bytes out on a valid/ready byte stream, or commands the controller to drop the frame. It replaces software polling of `Rx_SC`, `Rx_Len` and `Rx_Buff` in the system.

## Interface
Parameters:
- `MAX_FRAME`, 126: largest accepted payload length in bytes. Larger lengths are dropped.
- `CNT_W`, 16: width of the frame and drop counters.

Ports:
- `Clk`  in  1  system clock; all logic on rising edge
- `Rst`  in  1  reset, synchronous, active-high
- `Rx_Ready`  in  1  controller has a complete frame buffered
- `Address`  out  3  register address to controller
- `WriteEnable`  out  1  one-cycle register write strobe
- `ReadEnable`  out  1  one-cycle register read strobe
- `WrData`  out  8  write data, connects to controller `DataIn`
- `RdData`  in  8  read data from controller `DataOut`, valid the cycle after `ReadEnable`
- `M_Data`  out  8  payload byte
- `M_Valid`  out  1  `M_Data` valid
- `M_Ready`  in  1  downstream accepts the byte
- `M_First`  out  1  qualifies first byte of frame
- `M_Last`  out  1  qualifies last byte of frame
- `FrameDone`  out  1  one-cycle pulse after the last byte is accepted
- `FrameDropped`  out  1  one-cycle pulse when a drop is written
- `FrameCount`  out  CNT_W  delivered frames, wraps
- `DropCount`  out  CNT_W  dropped frames, saturates at all-ones

## Operation
- Register map used: 2 = `Rx_SC`, 3 = `Rx_Buff`, 4 = `Rx_Len`. `Rx_SC` read bits are [0] Ready, [2] FrameError, [3] AbortSignal, [4] Overflow. Writing `Rx_SC` with bit [1] set means Drop.
- FSM states:
  - IDLE: when `Rx_Ready`=1, go to RD_SC.
  - RD_SC: `ReadEnable`=1, `Address`=2; go to CAP_SC.
  - CAP_SC: if any of `RdData`[4:2] is set, go to DROP; else go to RD_LEN.
  - RD_LEN: `ReadEnable`=1, `Address`=4; go to CAP_LEN.
  - CAP_LEN: latch len = `RdData`; clear idx. If len=0 or len>`MAX_FRAME`, go to DROP; else go to RD_BUF.
  - RD_BUF: `ReadEnable`=1, `Address`=3; go to CAP_BUF.
  - CAP_BUF: latch `M_Data` = `RdData`; go to PUSH.
  - PUSH: `M_Valid`=1. `M_First` = (idx==0). `M_Last` = (idx==len-1). On `M_Ready`, increment idx. Then, if it was the last byte, pulse `FrameDone`, increment `FrameCount` and go to GAP; else go to RD_BUF.
  - DROP: `WriteEnable`=1, `Address`=2, `WrData`=8'h02 for one cycle; pulse `FrameDropped`; increment `DropCount` with saturation; go to GAP.
  - GAP: wait until `Rx_Ready`=0, then go to IDLE. This prevents re-reading the same frame.
- `M_Data`, `M_First` and `M_Last` are held stable while `M_Valid`=1 and `M_Ready`=0.
- At most one of `ReadEnable` and `WriteEnable` is high in any cycle.
- `Address` and `WrData` are 0 whenever no strobe is active.
- idx and len are 8 bits. idx never exceeds len.

## Timing
- All outputs are registered, with one exception: `M_Valid`, `M_First` and `M_Last` are decoded from the registered state and idx.
- Reset values: state IDLE; `Address`=0, `WriteEnable`=0, `ReadEnable`=0, `WrData`=0, `M_Data`=0, `M_Valid`=0, `M_First`=0, `M_Last`=0, `FrameDone`=0, `FrameDropped`=0, `FrameCount`=0, `DropCount`=0.
- `Rx_Ready` rising to first `ReadEnable` (RD_SC): 1 cycle after IDLE samples it.
- Status to first byte valid: RD_SC, CAP_SC, RD_LEN, CAP_LEN, RD_BUF, CAP_BUF, then PUSH. `M_Valid` is high 6 cycles after the RD_SC cycle.
- Sustained rate with `M_Ready`=1: one byte per 3 cycles (RD_BUF, CAP_BUF, PUSH).
- `FrameDone` is high in the cycle after the accepting PUSH cycle. `FrameCount` updates in the same cycle.
- Reset asserted mid-frame returns the block to IDLE on the next edge with all outputs cleared. No `M_Last` is produced for the truncated frame, so downstream must be reset with it. The controller buffer is not dropped.
- If `Rx_Ready` falls during a read sequence, it is ignored until GAP.

## Test plan
- Good frame: `Rx_SC`=0x01, `Rx_Len`=3, bytes A5,5A,FF, `M_Ready`=1. Expect 3 reads at addr 3 and the stream A5(First), 5A, FF(Last). `FrameDone` pulses once, `FrameCount`=1, no writes.
- Backpressure: same frame with `M_Ready` low 4 cycles on the second byte. Expect `M_Data`=5A held stable and no extra `ReadEnable` until accepted. Final stream is unchanged.
- Error drop: `Rx_SC`=0x11 (Overflow). Expect exactly one write with `Address`=2, `WrData`=0x02, `FrameDropped` pulse, `DropCount`=1, `M_Valid` never high, and no read of addr 3 or 4.
- Length bounds: `Rx_Len`=0, then `Rx_Len`=127. Both frames are dropped (`DropCount`=2). `Rx_Len`=126 delivers 126 bytes with `M_Last` on idx 125.
- GAP hold: keep `Rx_Ready`=1 for 20 cycles after `FrameDone`. Expect no new `ReadEnable` until `Rx_Ready` has been sampled 0.
- Reset mid-stream: assert `Rst` during PUSH of byte 2 of 5. Next cycle all outputs are at reset values. A new frame afterwards is delivered correctly with `FrameCount`=1.
